// File: rtl/exec_mdu_alu.sv
// exec_mdu_alu: single-issue execute unit.
// Simple ALU ops (ADD/SUB/AND/OR/XOR/SLT) complete one cycle after acceptance and drive result/ovf.
// MULT/MULTU/DIV/DIVU run a 32-step shift-add / restoring-divide loop and write HI/LO on DONE entry.
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle multiply; divide stays iterative).
module exec_mdu_alu (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic [4:0]  aluctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        ready_in,
    output logic        valid_out,
    output logic [31:0] result,
    output logic        ovf,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Control codes shared with the decode stage.
    localparam logic [4:0] AluAdd   = 5'd0;
    localparam logic [4:0] AluSub   = 5'd1;
    localparam logic [4:0] AluAnd   = 5'd2;
    localparam logic [4:0] AluOr    = 5'd3;
    localparam logic [4:0] AluSlt   = 5'd4;
    localparam logic [4:0] AluXor   = 5'd5;
    localparam logic [4:0] AluMult  = 5'd6;
    localparam logic [4:0] AluMultu = 5'd7;
    localparam logic [4:0] AluDiv   = 5'd8;
    localparam logic [4:0] AluDivu  = 5'd9;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic        neg_q, neg_d;      // negate product / quotient at the end
    logic        rneg_q, rneg_d;    // negate remainder (signed dividend was negative)
    logic        dz_q, dz_d;        // divide by zero
    logic [31:0] araw_q, araw_d;    // raw dividend, returned in HI on divide by zero
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_mul, is_div, is_sgn;
    logic [31:0] mag_a, mag_b, sum, diff, alu_res;
    logic        alu_ovf;

    // Operand decode and the single-cycle ALU datapath.
    always_comb begin
        is_mul  = (aluctrl == AluMult) || (aluctrl == AluMultu);
        is_div  = (aluctrl == AluDiv) || (aluctrl == AluDivu);
        is_sgn  = (aluctrl == AluMult) || (aluctrl == AluDiv);
        mag_a   = (is_sgn && a[31]) ? (32'd0 - a) : a;
        mag_b   = (is_sgn && b[31]) ? (32'd0 - b) : b;
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (aluctrl)
            AluAdd: begin
                alu_res = sum;
                alu_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            AluSub: begin
                alu_res = diff;
                alu_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            AluAnd:  alu_res = a & b;
            AluOr:   alu_res = a | b;
            AluXor:  alu_res = a ^ b;
            AluSlt:  alu_res = {31'b0, $signed(a) < $signed(b)};
            default: ;
        endcase
    end

`ifdef MDU_FAST_MUL_EN
    logic [63:0] ext_a, ext_b, fast_prod;

    // Single-cycle multiply; low 64 bits of the sign-extended product are exact for both signednesses.
    always_comb begin
        ext_a     = {{32{is_sgn & a[31]}}, a};
        ext_b     = {{32{is_sgn & b[31]}}, b};
        fast_prod = ext_a * ext_b;
    end
`endif

    logic [32:0] mul_sum, div_shift, div_diff;
    logic [63:0] mul_next, div_next, mul_fin;
    logic [31:0] quo_fin, rem_fin;

    // One multiply / divide step plus the final sign fix-up applied on DONE entry.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};
        mul_fin   = neg_q ? (64'd0 - mul_next) : mul_next;
        quo_fin   = dz_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - div_next[31:0]) : div_next[31:0]);
        rem_fin   = dz_q ? araw_q : (rneg_q ? (32'd0 - div_next[63:32]) : div_next[63:32]);
    end

    // Next-state logic: acceptance, iteration, completion and flush.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        araw_d   = araw_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            StIdle: begin
                if (valid_in && !flush) begin
                    cnt_d  = 5'd0;
                    araw_d = a;
                    if (is_mul) begin
`ifdef MDU_FAST_MUL_EN
                        state_d      = StDone;
                        {hi_d, lo_d} = fast_prod;
                        ovf_d        = 1'b0;
`else
                        state_d = StMul;
                        acc_d   = {32'd0, mag_b};
                        opnd_d  = mag_a;
                        neg_d   = is_sgn && (a[31] ^ b[31]);
`endif
                    end else if (is_div) begin
                        state_d = StDiv;
                        acc_d   = {32'd0, mag_a};
                        opnd_d  = mag_b;
                        neg_d   = is_sgn && (a[31] ^ b[31]);
                        rneg_d  = is_sgn && a[31];
                        dz_d    = (b == 32'd0);
                    end else begin
                        state_d  = StDone;
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                    end
                end
            end
            StMul: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                end else begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d      = StDone;
                        cnt_d        = 5'd0;
                        {hi_d, lo_d} = mul_fin;
                        ovf_d        = 1'b0;
                    end
                end
            end
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StDone;
                        cnt_d   = 5'd0;
                        hi_d    = rem_fin;
                        lo_d    = quo_fin;
                        ovf_d   = 1'b0;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and architectural registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            araw_q   <= 32'd0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            araw_q   <= araw_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign ready_in  = (state_q == StIdle);
    assign valid_out = (state_q == StDone);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: doc/exec_mdu_alu.md
EXEC_MDU_ALU -- requirements
Module: exec_mdu_alu

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port valid_in, input, 1 bit: an operation is presented this cycle.
REQ-004 The block SHALL have port aluctrl, input, 5 bits: ALU control code from the decoder, using the shared control-code header values (ADD, SUB, AND, OR, SLT, XOR, MULT, MULTU, DIV, DIVU).
REQ-005 The block SHALL have ports a and b, input, 32 bits each: source operands.
REQ-006 The block SHALL have port flush, input, 1 bit: abort the in-flight operation.
REQ-007 The block SHALL have port ready_in, output, 1 bit: the block can accept an operation this cycle.
REQ-008 The block SHALL have port valid_out, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port result, output, 32 bits: registered simple-op result.
REQ-010 The block SHALL have port ovf, output, 1 bit: signed overflow of ADD/SUB, qualified by valid_out.
REQ-011 The block SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers.

Function
REQ-012 An operation SHALL be accepted on a rising edge where valid_in=1, ready_in=1 and flush=0.
REQ-013 ready_in SHALL be 1 only in state IDLE.
REQ-014 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-015 IDLE SHALL transition to MUL on MULT/MULTU, to DIV on DIV/DIVU, and to DONE on any other code.
REQ-016 MUL and DIV SHALL each perform one iteration per cycle for 32 cycles (5-bit counter, 0 to 31), then transition to DONE.
REQ-017 DONE SHALL assert valid_out for exactly one cycle and return to IDLE on the next edge.
REQ-018 Latency from the accepting edge to valid_out SHALL be 1 cycle for simple ops and 33 cycles for iterative ops.
REQ-019 Simple ops SHALL compute: ADD/SUB as 32-bit wrap; AND/OR/XOR bitwise; SLT as signed compare producing 1 or 0.
REQ-020 An unknown aluctrl code SHALL produce result=0 and ovf=0, with simple-op latency.
REQ-021 ovf SHALL be 1 only for ADD/SUB with signed overflow; result SHALL still carry the wrapped value.
REQ-022 MULT/MULTU SHALL produce a 64-bit signed/unsigned product with {hi,lo}=product.
REQ-023 DIV/DIVU SHALL use restoring division on magnitudes with lo=quotient and hi=remainder.
REQ-024 Signed division SHALL give the remainder the sign of a and the quotient truncated toward zero.
REQ-025 Divide by zero SHALL still take 33 cycles and produce lo=0xFFFFFFFF and hi=a.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0.
REQ-027 hi/lo SHALL update only on the DONE entry edge of an iterative op; simple ops SHALL leave hi/lo unchanged.
REQ-028 result SHALL hold its last value when no simple op completes.
REQ-029 In any state, flush=1 SHALL return the FSM to IDLE on the next edge, with no valid_out and no hi/lo update.
REQ-030 flush=1 together with valid_in=1 in IDLE SHALL drop the operation.
REQ-031 valid_in SHALL be ignored while ready_in=0.
REQ-032 Operands SHALL be latched at acceptance; later changes on a and b SHALL not affect an in-flight op.

Reset
REQ-033 resetn=0 SHALL asynchronously force state=IDLE, counter=0, valid_out=0, result=0, ovf=0, hi=0, lo=0.
REQ-034 While resetn=0, ready_in SHALL be 1.
REQ-035 Reset asserted mid-operation SHALL discard the operation with no completion pulse after release.
REQ-036 The first acceptance SHALL be possible on the first rising edge after resetn deasserts.

Configuration
REQ-037 With MDU_FAST_MUL_EN defined, MULT/MULTU SHALL compute in one cycle (IDLE to DONE directly, 1-cycle latency), with identical hi/lo values.
REQ-038 With MDU_FAST_MUL_EN undefined, multiply SHALL be iterative per REQ-016.
REQ-039 Division SHALL be iterative in both configurations.

Verification
REQ-040 ADD a=0x7FFFFFFF, b=1 -> valid_out after 1 cycle, result=0x80000000, ovf=1; then SLT a=0xFFFFFFFF, b=0 -> result=1.
REQ-041 MULT a=0xFFFFFFFE (-2), b=3 -> valid_out at cycle 33 (cycle 1 with MDU_FAST_MUL_EN), hi=0xFFFFFFFF, lo=0xFFFFFFFA; ready_in=0 throughout.
REQ-042 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-043 Start DIVU, assert flush at cycle 10 -> IDLE next cycle, no valid_out, hi/lo unchanged, ready_in=1.
REQ-044 Start MULTU 0xFFFFFFFF*0xFFFFFFFF, drop resetn at cycle 5 -> all outputs 0 immediately, no valid_out after release.
REQ-045 Hold valid_in=1 with changing a, b during a divide -> only the first op completes, with operands as latched.
